// File: rtl/data_sram_responder.sv
// Cycle-accurate data-memory slave for the CPU's sram-like data port.
// It accepts one request per cycle and answers each one in order after a fixed LATENCY.
module data_sram_responder #(
    parameter int AW_WORDS = 10,
    parameter int LATENCY  = 2,
    parameter int QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int              DEPTH      = 1 << AW_WORDS;
    localparam int              PW         = $clog2(QDEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [2:0]      TIMER_LOAD = 3'(LATENCY - 1);
    localparam logic [CW-1:0]   COUNT_FULL = CW'(QDEPTH);

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic [2:0]  timer;
    } entry_t;

    logic [31:0]         mem_q [DEPTH];
    logic [AW_WORDS-1:0] word_idx;
    logic [31:0]         mem_rdata;

    entry_t              q_q [QDEPTH];
    entry_t              q_d [QDEPTH];
    logic [QDEPTH-1:0]   valid_q, valid_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;

    entry_t              head_entry;
    logic                accept;
    logic                retire;

    // Size and the byte-lane/upper address bits do not affect indexing.
    logic unused_inputs;
    assign unused_inputs = ^{data_sram_size, data_sram_addr[1:0],
                             data_sram_addr[31:AW_WORDS+2]};

    assign word_idx   = data_sram_addr[AW_WORDS+1:2];
    assign mem_rdata  = mem_q[word_idx];

    // Full is judged on the registered count only, so a retire never reopens the port early.
    assign data_sram_addr_ok = (count_q < COUNT_FULL);
    assign accept            = data_sram_req && data_sram_addr_ok;

    assign head_entry        = q_q[head_q];
    assign retire            = valid_q[head_q] && (head_entry.timer == 3'd0);
    assign data_sram_data_ok = retire;
    assign data_sram_rdata   = (retire && head_entry.is_read) ? head_entry.data : 32'd0;

    // NOTE: the memory array has no reset branch; its contents must survive reset
    // and a reset on every word would also stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: every next-state signal takes its current value first, so no path through
    // this block leaves one unassigned and no latch can be inferred.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;

        for (int i = 0; i < QDEPTH; i++) begin
            if (valid_q[i] && (q_q[i].timer != 3'd0)) begin
                q_d[i].timer = q_q[i].timer - 3'd1;
            end
        end

        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        // An accept never lands on the retiring slot: accept implies not full.
        if (accept) begin
            valid_d[tail_q]     = 1'b1;
            q_d[tail_q].is_read = !data_sram_wr;
            q_d[tail_q].data    = data_sram_wr ? 32'd0 : mem_rdata;
            q_d[tail_q].timer   = TIMER_LOAD;
            tail_d              = tail_q + PW'(1);
        end

        count_d = count_q + CW'(accept) - CW'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: a LATENCY=2 and a LATENCY=7 instance,
// a per-cycle vector table plus hand-written fill, streaming and reset sequences.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [2];
    logic        wr    [2];
    logic [1:0]  size  [2];
    logic [3:0]  strb  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        aok   [2];
    logic        dok   [2];
    logic [31:0] rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.AW_WORDS(10), .LATENCY(2), .QDEPTH(4)) u_l2 (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req[0]),
        .data_sram_wr      (wr[0]),
        .data_sram_size    (size[0]),
        .data_sram_wstrb   (strb[0]),
        .data_sram_addr    (addr[0]),
        .data_sram_wdata   (wdata[0]),
        .data_sram_addr_ok (aok[0]),
        .data_sram_data_ok (dok[0]),
        .data_sram_rdata   (rdata[0])
    );

    data_sram_responder #(.AW_WORDS(10), .LATENCY(7), .QDEPTH(4)) u_l7 (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req[1]),
        .data_sram_wr      (wr[1]),
        .data_sram_size    (size[1]),
        .data_sram_wstrb   (strb[1]),
        .data_sram_addr    (addr[1]),
        .data_sram_wdata   (wdata[1]),
        .data_sram_addr_ok (aok[1]),
        .data_sram_data_ok (dok[1]),
        .data_sram_rdata   (rdata[1])
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input int u, input string tag, input logic e_aok,
                              input logic e_dok, input logic [31:0] e_rdata);
        check({tag, " addr_ok"}, 32'(aok[u]), 32'(e_aok));
        check({tag, " data_ok"}, 32'(dok[u]), 32'(e_dok));
        check({tag, " rdata"},   rdata[u],    e_rdata);
    endtask

    task automatic drive(input int u, input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req[u]   = r;
        wr[u]    = w;
        size[u]  = 2'b10;
        strb[u]  = s;
        addr[u]  = a;
        wdata[u] = d;
    endtask

    task automatic idle(input int u);
        drive(u, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Called at a falling edge; returns at the falling edge of the first cycle after reset.
    task automatic do_reset();
        idle(0);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream_data [16];
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rd;

        //              req   wr    strb   addr        wdata          aok   dok   rdata
        vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'h2, 32'h11, 32'h0000AA00, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hDEADAAEF};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h12345678};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 4'hF, 32'h30, 32'h11112222, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 4'hC, 32'h30, 32'hCAFE0000, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 4'h0, 32'h30, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h33, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b1, 32'hCAFE2222};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b1, 32'hCAFE2222};
        vecs[16] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};

        reset = 1'b1;
        idle(0);
        idle(1);
        @(negedge clk);
        do_reset();

        check_outs(1, "l7 reset", 1'b1, 1'b0, 32'h0);

        // Table: vector i is driven in cycle i and its expectations are observed in cycle i.
        for (int i = 0; i < 17; i++) begin
            check_outs(0, $sformatf("vec%0d", i), vecs[i].exp_aok, vecs[i].exp_dok,
                       vecs[i].exp_rdata);
            drive(0, vecs[i].req, vecs[i].wr, vecs[i].strb, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
        end

        // Streaming: fill 0x0..0x3C, drain, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            stream_data[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0011;
            check($sformatf("fill%0d addr_ok", i), 32'(aok[0]), 32'h1);
            drive(0, 1'b1, 1'b1, 4'hF, 32'(i * 4), stream_data[i]);
            @(negedge clk);
        end
        idle(0);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 19; j++) begin
            e_dok = (j >= 2) && (j <= 17);
            e_rd  = e_dok ? stream_data[j-2] : 32'h0;
            check_outs(0, $sformatf("stream%0d", j), 1'b1, e_dok, e_rd);
            if (j < 16) drive(0, 1'b1, 1'b0, 4'h0, 32'(j * 4), 32'h0);
            else        idle(0);
            @(negedge clk);
        end

        // Fill to QDEPTH with LATENCY=7 while req is held high.
        do_reset();
        for (int c = 0; c < 17; c++) begin
            e_aok = (c < 4) || ((c >= 8) && (c < 12)) || (c == 16);
            e_dok = ((c >= 7) && (c <= 10)) || ((c >= 15) && (c <= 18));
            e_rd  = (e_dok && c != 7) ? 32'h0BADF00D : 32'h0;
            check_outs(1, $sformatf("full%0d", c), e_aok, e_dok, e_rd);
            if (c == 0) drive(1, 1'b1, 1'b1, 4'hF, 32'h40, 32'h0BADF00D);
            else        drive(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
            @(negedge clk);
        end
        idle(1);
        repeat (12) @(negedge clk);

        // Reset with a write and three reads outstanding.
        check_outs(1, "pre-rst", 1'b1, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b1, 4'hF, 32'h44, 32'h600DCAFE);
        @(negedge clk);
        for (int c = 1; c < 4; c++) begin
            drive(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
            @(negedge clk);
        end
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(" post-rst addr_ok", 32'(aok[1]), 32'h1);
        for (int c = 5; c < 15; c++) begin
            check($sformatf("post-rst%0d data_ok", c), 32'(dok[1]), 32'h0);
            @(negedge clk);
        end
        drive(1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        @(negedge clk);
        idle(1);
        for (int c = 1; c < 7; c++) begin
            check($sformatf("reread wait%0d data_ok", c), 32'(dok[1]), 32'h0);
            @(negedge clk);
        end
        check_outs(1, "reread", 1'b1, 1'b1, 32'h600DCAFE);
        @(negedge clk);
        check(" reread after data_ok", 32'(dok[1]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
